lfsr_checker: RTL and testbench

Receive-side checker for the 4-bit maximal-length LFSR pattern (polynomial x^4+x^3+1, period 15) produced by the `lfsr` generator. It consumes one 4-bit state word per valid cycle and self-synchronises to the incoming sequence. Once locked, it flywheels its own prediction, counts mismatches and declares loss of lock. It sits at the far end of a link or loopback path as the pattern-integrity monitor.

---
 rtl/lfsr_checker.sv | 102 ++++++++++
 tb/tb_lfsr_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the x^4+x^3+1 LFSR pattern: self-synchronises,
// flywheels its prediction once locked, and counts mismatches.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt
);

    localparam logic S_SEARCH = 1'b0;
    localparam logic S_LOCKED = 1'b1;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    logic       state;
    logic [3:0] ref_q;
    logic       have_ref;
    logic [3:0] run_cnt;
    logic [3:0] miss_cnt;

    logic [3:0] exp_word;
    logic       match;
    logic [3:0] run_inc;
    logic [3:0] miss_inc;
    logic       count_err;

    // 0000 is the LFSR lock-up state: its successor is itself, so exclude it explicitly
    always_comb begin
        exp_word  = {ref_q[2:0], ref_q[3] ^ ref_q[2]};
        match     = (in_data == exp_word) && (in_data != 4'b0000);
        run_inc   = run_cnt + 4'd1;
        miss_inc  = miss_cnt + 4'd1;
        count_err = in_valid && (state == S_LOCKED) && !match;
    end

    assign locked = (state == S_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_SEARCH;
            ref_q    <= '0;
            have_ref <= 1'b0;
            run_cnt  <= '0;
            miss_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= count_err;
            if (in_valid) begin
                case (state)
                    S_SEARCH: begin
                        ref_q <= in_data;
                        if (!have_ref) begin
                            have_ref <= 1'b1;
                            run_cnt  <= '0;
                        end else if (match) begin
                            run_cnt <= run_inc;
                            if (run_inc == LOCK_TGT) begin
                                state    <= S_LOCKED;
                                miss_cnt <= '0;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    default: begin
                        if (match) begin
                            ref_q    <= in_data;
                            miss_cnt <= '0;
                        end else if (miss_inc == LOSS_TGT) begin
                            // Giving up: restart the search from the word just seen
                            state    <= S_SEARCH;
                            run_cnt  <= '0;
                            ref_q    <= in_data;
                            have_ref <= 1'b1;
                            miss_cnt <= miss_inc;
                        end else begin
                            ref_q    <= exp_word;
                            miss_cnt <= miss_inc;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            err_cnt <= '0;
        end else if (count_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: table-driven vectors through a scoreboard queue,
// plus a second instance driven to err_cnt saturation.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'b0000;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;

    logic        s_rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [3:0]  s_data = 4'b0000;
    logic        s_clr = 1'b0;
    logic        s_locked;
    logic        s_err;
    logic [15:0] s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(15)) dut_sat (
        .clk(clk), .rst(s_rst), .in_valid(s_valid), .in_data(s_data),
        .clr_cnt(s_clr), .locked(s_locked), .err(s_err), .err_cnt(s_cnt)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [3:0]  d;
        logic        c;
        logic        lk;
        logic        er;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        lk;
        logic        er;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [3:0] step(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic void addv(input logic r, input logic v, input logic [3:0] d,
                                 input logic c, input logic lk, input logic er,
                                 input logic [15:0] cnt);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.c = c; t.lk = lk; t.er = er; t.cnt = cnt;
        vecs.push_back(t);
    endfunction

    task automatic gap3(input logic [15:0] cnt);
        for (int i = 0; i < 3; i++) addv(0, 0, 4'b0000, 0, 1, 0, cnt);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("vec%0d.locked", e.idx), {15'd0, locked}, {15'd0, e.lk});
            chk($sformatf("vec%0d.err", e.idx), {15'd0, err}, {15'd0, e.er});
            chk($sformatf("vec%0d.err_cnt", e.idx), err_cnt, e.cnt);
        end
    end

    initial begin
        // reset, acquisition
        addv(1, 0, 4'b0000, 0, 0, 0, 0);
        addv(0, 1, 4'b0001, 0, 0, 0, 0);
        addv(0, 1, 4'b0010, 0, 0, 0, 0);
        addv(0, 1, 4'b0100, 0, 0, 0, 0);
        addv(0, 1, 4'b1001, 0, 0, 0, 0);
        addv(0, 1, 4'b0011, 0, 1, 0, 0);
        addv(0, 1, 4'b0110, 0, 1, 0, 0);
        addv(0, 1, 4'b1101, 0, 1, 0, 0);
        addv(0, 1, 4'b1010, 0, 1, 0, 0);
        addv(0, 1, 4'b0101, 0, 1, 0, 0);
        addv(0, 1, 4'b1011, 0, 1, 0, 0);
        addv(0, 1, 4'b0111, 0, 1, 0, 0);
        addv(0, 1, 4'b1111, 0, 1, 0, 0);
        addv(0, 1, 4'b1110, 0, 1, 0, 0);
        // wrap with gaps
        addv(0, 1, 4'b1100, 0, 1, 0, 0); gap3(0);
        addv(0, 1, 4'b1000, 0, 1, 0, 0); gap3(0);
        addv(0, 1, 4'b0001, 0, 1, 0, 0); gap3(0);
        addv(0, 1, 4'b0010, 0, 1, 0, 0);
        addv(0, 1, 4'b0100, 0, 1, 0, 0);
        addv(0, 1, 4'b1001, 0, 1, 0, 0);
        addv(0, 1, 4'b0011, 0, 1, 0, 0);
        // single error flywheel
        addv(0, 1, 4'b0000, 0, 1, 1, 1);
        addv(0, 1, 4'b1101, 0, 1, 0, 1);
        // loss of lock
        addv(0, 1, 4'b1111, 0, 1, 1, 2);
        addv(0, 1, 4'b1111, 0, 1, 1, 3);
        addv(0, 1, 4'b1111, 0, 0, 1, 4);
        addv(0, 1, 4'b0111, 0, 0, 0, 4);
        addv(0, 1, 4'b1111, 0, 0, 0, 4);
        addv(0, 1, 4'b1110, 0, 0, 0, 4);
        addv(0, 1, 4'b1100, 0, 0, 0, 4);
        addv(0, 1, 4'b1000, 0, 1, 0, 4);
        addv(0, 1, 4'b0001, 0, 1, 0, 4);
        // clear coincident with an error
        addv(0, 1, 4'b0000, 1, 1, 1, 0);
        addv(0, 1, 4'b0100, 0, 1, 0, 0);
        // isolated errors alternating with good words
        addv(0, 1, 4'b0000, 0, 1, 1, 1);
        addv(0, 1, 4'b0011, 0, 1, 0, 1);
        addv(0, 1, 4'b0000, 0, 1, 1, 2);
        addv(0, 1, 4'b1101, 0, 1, 0, 2);
        addv(0, 1, 4'b0000, 0, 1, 1, 3);
        addv(0, 1, 4'b0101, 0, 1, 0, 3);
        addv(0, 1, 4'b0000, 0, 1, 1, 4);
        addv(0, 1, 4'b0111, 0, 1, 0, 4);
        addv(0, 1, 4'b0000, 0, 1, 1, 5);
        addv(0, 1, 4'b1110, 0, 1, 0, 5);
        // reset mid-lock, relock with normal latency
        addv(1, 1, 4'b1100, 0, 0, 0, 0);
        addv(0, 1, 4'b0001, 0, 0, 0, 0);
        addv(0, 1, 4'b0010, 0, 0, 0, 0);
        addv(0, 1, 4'b0100, 0, 0, 0, 0);
        addv(0, 1, 4'b1001, 0, 0, 0, 0);
        addv(0, 1, 4'b0011, 0, 1, 0, 0);
        // all-zero stream must never lock
        addv(1, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) addv(0, 1, 4'b0000, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            rst      = vecs[i].r;
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            clr_cnt  = vecs[i].c;
            e.idx = i; e.lk = vecs[i].lk; e.er = vecs[i].er; e.cnt = vecs[i].cnt;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        // saturation on the second instance
        begin
            logic [3:0] s;
            int bads;
            int miss;
            @(negedge clk);
            s_rst = 1'b0;
            s = 4'b0001;
            s_valid = 1'b1;
            s_data = s;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                s = step(s);
                s_data = s;
            end
            @(posedge clk); #1;
            chk("sat.locked", {15'd0, s_locked}, 16'd1);
            bads = 0;
            miss = 0;
            while (bads < 65535) begin
                @(negedge clk);
                s = step(s);
                if (miss == 14) begin
                    s_data = s;
                    miss = 0;
                end else begin
                    s_data = 4'b0000;
                    miss++;
                    bads++;
                end
            end
            @(negedge clk);
            s = step(s);
            s_data = s;
            @(posedge clk); #1;
            chk("sat.reach", s_cnt, 16'hFFFF);
            @(negedge clk);
            s = step(s);
            s_data = 4'b0000;
            @(posedge clk); #1;
            chk("sat.hold", s_cnt, 16'hFFFF);
            chk("sat.err", {15'd0, s_err}, 16'd1);
            chk("sat.still_locked", {15'd0, s_locked}, 16'd1);
            @(negedge clk);
            s = step(s);
            s_data = 4'b0000;
            s_clr = 1'b1;
            @(posedge clk); #1;
            chk("sat.clr_cnt", s_cnt, 16'h0000);
            chk("sat.clr_err", {15'd0, s_err}, 16'd1);
            @(negedge clk);
            s_clr = 1'b0;
            s_valid = 1'b0;
            @(posedge clk); #1;
            chk("sat.idle_err", {15'd0, s_err}, 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
